// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : iterative MULT/MULTU/DIV/DIVU unit with HI/LO, one bit per cycle
// Rev 1.0
// ============================================================================
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             rd_hilo,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam int                 c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state, w_next_state;
  logic [c_CNT_W-1:0]   r_count;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic                 r_is_div, r_neg_q, r_neg_r, r_b_zero;
  logic [WIDTH-1:0]     r_hi, r_lo;
  logic                 r_done, r_dz;

  logic                 w_signed, w_accept, w_mt_issue;
  logic [WIDTH-1:0]     w_abs_a, w_abs_b;
  logic [WIDTH:0]       w_sum, w_rem, w_diff;
  logic [2*WIDTH-1:0]   w_mul_acc, w_div_acc, w_prod;
  logic [WIDTH-1:0]     w_q, w_r, w_fix_hi, w_fix_lo;

  assign w_signed   = ~op[0];
  assign w_accept   = (r_state == S_IDLE) & start & ~cancel & ~op[2];
  assign w_mt_issue = (r_state == S_IDLE) & start & ~cancel & (op[2:1] == 2'b10);
  assign w_abs_a    = (w_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign w_abs_b    = (w_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  // Multiply: add multiplicand into the upper half when the low bit is set, shift right.
  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : {WIDTH{1'b0}})};
  assign w_mul_acc = {w_sum, r_acc[WIDTH-1:1]};

  // Divide: restoring step, quotient bits shift in at the bottom.
  assign w_rem     = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_rem - {1'b0, r_opnd};
  assign w_div_acc = w_diff[WIDTH] ? {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                   : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
  assign w_q    = r_acc[WIDTH-1:0];
  assign w_r    = r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      w_fix_hi = r_neg_r ? (~w_r + 1'b1) : w_r;
      if (r_b_zero)
        w_fix_lo = {WIDTH{1'b1}};
      else
        w_fix_lo = r_neg_q ? (~w_q + 1'b1) : w_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next_state = S_RUN;
      S_RUN:   if (cancel) w_next_state = S_IDLE;
               else if (r_count == c_LAST) w_next_state = S_FIX;
      S_FIX:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_count  <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_count  <= '0;
            r_is_div <= op[1];
            r_neg_q  <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg_r  <= w_signed & a[WIDTH-1];
            r_b_zero <= op[1] & (b == '0);
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
            r_opnd   <= op[1] ? w_abs_b : w_abs_a;
          end else if (w_mt_issue) begin
            if (op[0]) r_lo <= a;
            else       r_hi <= a;
          end
        end
        S_RUN: begin
          if (!cancel) begin
            r_count <= r_count + c_CNT_W'(1);
            r_acc   <= r_is_div ? w_div_acc : w_mul_acc;
          end
        end
        S_FIX: begin
          if (!cancel) begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
            r_dz   <= r_b_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi       = r_hi;
  assign lo       = r_lo;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign div_zero = r_dz;
  assign stall    = busy & (start | rd_hilo);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// Randomized + directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, cancel, rd_hilo;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, div_zero, stall;

  logic        start8, cancel8, rd_hilo8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, div_zero8, stall8;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .rd_hilo(rd_hilo), .hi(hi), .lo(lo), .busy(busy),
    .done(done), .div_zero(div_zero), .stall(stall)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .cancel(cancel8), .rd_hilo(rd_hilo8), .hi(hi8), .lo(lo8), .busy(busy8),
    .done(done8), .div_zero(div_zero8), .stall(stall8)
  );

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic at width w.
  task automatic model(input int w, input logic [2:0] mop, input longint unsigned ua,
                       input longint unsigned ub, output longint unsigned ehi,
                       output longint unsigned elo, output logic edz);
    longint mask, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    sa = longint'(ua);
    sb = longint'(ub);
    if (!mop[0] && ua[w-1]) sa = sa - (longint'(1) << w);
    if (!mop[0] && ub[w-1]) sb = sb - (longint'(1) << w);
    edz = 1'b0;
    if (!mop[1]) begin
      p   = sa * sb;
      ehi = longint'(p >> w) & mask;
      elo = p & mask;
    end else if (ub == 0) begin
      elo = mask;
      ehi = ua;
      edz = 1'b1;
    end else begin
      q   = sa / sb;
      r   = sa % sb;
      elo = q & mask;
      ehi = r & mask;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] iop, input logic [31:0] ia, input logic [31:0] ib);
    start = 1'b1; op = iop; a = ia; b = ib;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 3'b111;
  endtask

  // Waits for done and checks latency and results; returns at the done cycle.
  task automatic finish_op(input string tag, input logic [2:0] iop, input logic [31:0] ia,
                           input logic [31:0] ib);
    int lat;
    longint unsigned ehi, elo;
    logic edz;
    check({tag, " busy"}, busy, 1);
    check({tag, " done_low"}, done, 0);
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 33);
    model(32, iop, ia, ib, ehi, elo, edz);
    check({tag, " hi"}, hi, ehi);
    check({tag, " lo"}, lo, elo);
    check({tag, " div_zero"}, div_zero, edz);
    check({tag, " idle"}, busy, 0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] iop, input logic [31:0] ia,
                        input logic [31:0] ib);
    issue(iop, ia, ib);
    finish_op(tag, iop, ia, ib);
  endtask

  initial begin
    int cyc, bad, dcount;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    longint unsigned ehi, elo;
    logic edz;

    reset = 1'b0; start = 1'b0; cancel = 1'b0; rd_hilo = 1'b0;
    op = 3'b111; a = '0; b = '0;
    start8 = 1'b0; cancel8 = 1'b0; rd_hilo8 = 1'b0; op8 = 3'b111; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dz", div_zero, 0);
    check("reset stall", stall, 0);

    // Directed arithmetic, issued back-to-back in the done cycle.
    run_op("mult_neg", 3'b000, 32'hFFFFFFFD, 32'd7);
    @(negedge clk);
    check("mult_neg done_pulse", done, 0);
    run_op("divu_100_7", 3'b011, 32'd100, 32'd7);
    run_op("div_m7_2", 3'b010, 32'hFFFFFFF9, 32'd2);
    run_op("div_by_zero", 3'b010, 32'd5, 32'd0);
    run_op("div_neg_by_zero", 3'b010, 32'hFFFFFFFB, 32'd0);
    run_op("div_min_m1", 3'b010, 32'h80000000, 32'hFFFFFFFF);
    run_op("multu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);

    // Busy-time MFHI/MFLO and MTLO: stall held, MTLO only lands after done.
    issue(3'b001, 32'd3, 32'd5);
    cyc = 1; bad = 0;
    while (!done && cyc < 60) begin
      if (cyc == 3) rd_hilo = 1'b1;
      if (cyc == 5) begin start = 1'b1; op = 3'b101; a = 32'hDEAD; end
      #1;
      if (cyc >= 3 && !stall) bad++;
      if (lo == 32'hDEAD) bad++;
      @(negedge clk);
      cyc++;
    end
    check("busy_stall held", bad, 0);
    check("busy_stall latency", cyc, 34);
    check("busy_stall lo", lo, 15);
    check("busy_stall stall_drop", stall, 0);
    rd_hilo = 1'b0;
    @(negedge clk);
    check("mtlo reissued", lo, 32'hDEAD);
    start = 1'b0; op = 3'b111;

    // Preload, cancel in IDLE, cancel mid-op together with a start.
    issue(3'b100, 32'h1234, 32'd0);
    issue(3'b101, 32'h1234, 32'd0);
    check("mthi", hi, 32'h1234);
    check("mtlo", lo, 32'h1234);
    start = 1'b1; op = 3'b100; a = 32'hBEEF; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 3'b111; cancel = 1'b0;
    check("idle_cancel blocks mthi", hi, 32'h1234);
    issue(3'b001, 32'd9, 32'd9);
    repeat (9) @(negedge clk);
    cancel = 1'b1; start = 1'b1; op = 3'b100; a = 32'hBEEF;
    @(negedge clk);
    cancel = 1'b0; start = 1'b0; op = 3'b111;
    check("cancel busy", busy, 0);
    check("cancel hi", hi, 32'h1234);
    check("cancel lo", lo, 32'h1234);
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("cancel no_done", dcount, 0);

    // Reset mid-DIVU.
    issue(3'b011, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("midop_reset hi", hi, 0);
    check("midop_reset lo", lo, 0);
    check("midop_reset busy", busy, 0);
    check("midop_reset done", done, 0);
    run_op("after_reset divu", 3'b011, 32'd1000, 32'd3);

    // Randomized ops with corner-biased operands.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2:       rb = 32'($urandom_range(1, 15));
        3:       rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb);
    end
    @(negedge clk);

    // 8-bit instance.
    for (int i = 0; i < 12; i++) begin
      if (i == 0) begin
        rop = 3'b001; ra = 32'hFF; rb = 32'hFF;
      end else begin
        rop = 3'($urandom_range(0, 3));
        ra  = 32'($urandom_range(0, 255));
        rb  = (i % 4 == 1) ? 32'd0 : 32'($urandom_range(0, 255));
      end
      start8 = 1'b1; op8 = rop; a8 = ra[7:0]; b8 = rb[7:0];
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0; op8 = 3'b111;
      cyc = 0;
      while (!done8 && cyc < 30) begin
        @(negedge clk);
        cyc++;
      end
      model(8, rop, longint'(ra[7:0]), longint'(rb[7:0]), ehi, elo, edz);
      check($sformatf("w8_%0d latency", i), cyc, 9);
      check($sformatf("w8_%0d hi", i), hi8, ehi);
      check($sformatf("w8_%0d lo", i), lo8, elo);
      check($sformatf("w8_%0d dz", i), div_zero8, edz);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
